// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with NumSlaves active-low selects, runtime word
// length (1..MaxWordLen), runtime SCLK divider, CPOL/CPHA/bit-order control
// and multi-word bursts with SS held low between words.
// Optional build macro: SPI_SS_DELAY_EN adds SETUP/HOLD guard states of
// SSDelay SCLK half-periods around each burst.
module spi_master_multi #(
    parameter int MaxWordLen = 32,
    parameter int NumSlaves  = 4,
    parameter int DivWidth   = 8,
    parameter int SSDelay    = 2,
    localparam int SelW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
    localparam int LenW = (MaxWordLen > 1) ? $clog2(MaxWordLen) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  Endianess,
    input  logic [DivWidth-1:0]   ClkDiv,
    input  logic [SelW-1:0]       SlaveSel,
    input  logic [LenW-1:0]       WordLenM1,
    input  logic                  TxValid,
    output logic                  TxReady,
    input  logic [MaxWordLen-1:0] TxData,
    input  logic                  TxLast,
    output logic                  RxValid,
    output logic [MaxWordLen-1:0] RxData,
    output logic                  Busy,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [NumSlaves-1:0]  SS_n
);

    localparam int HpW = $clog2(SSDelay + 1) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, DONE} state_t;

`ifdef SPI_SS_DELAY_EN
    localparam state_t StartSt = SETUP;
    localparam state_t EndSt   = HOLD;
`else
    localparam state_t StartSt = SHIFT;
    localparam state_t EndSt   = DONE;
`endif

    state_t state, stateNext;

    // Burst configuration captured on the first handshake
    logic                  cpolR, cphaR, lsbR, lastR;
    logic [DivWidth-1:0]   divR;
    logic [SelW-1:0]       selR;
    logic [LenW-1:0]       lenR;

    logic [DivWidth-1:0]   divCnt;
    logic                  phase;      // 0: next edge is leading, 1: trailing
    logic [LenW:0]         bitCnt;
    logic [LenW-1:0]       bitNext;
    logic [HpW-1:0]        hpCnt;
    logic [MaxWordLen-1:0] txReg, rxReg, rxSampled;
    logic                  hs, tick, lastEdge, sampleNow, hpDone, ssActive;

    // Bit position of the idx-th transmitted bit for the chosen bit order
    function automatic logic [LenW-1:0] bitPos(input logic lsb, input logic [LenW-1:0] len,
                                               input logic [LenW-1:0] idx);
        return lsb ? idx : len - idx;
    endfunction

    assign TxReady   = !reset && (state == IDLE || state == NEXT);
    assign Busy      = (state != IDLE);
    assign hs        = TxValid && TxReady;
    assign tick      = (divCnt == divR);
    assign bitNext   = bitCnt[LenW-1:0] + 1'b1;
    assign lastEdge  = (state == SHIFT) && tick && phase && (bitCnt == {1'b0, lenR});
    assign sampleNow = (state == SHIFT) && tick && (phase == cphaR);
    assign hpDone    = (state == SETUP || state == HOLD) && tick && (hpCnt == HpW'(SSDelay - 1));
    assign ssActive  = (state != IDLE) && (state != DONE);
    // Out-of-range selects shift the one-hot off the top, leaving all deasserted
    assign SS_n      = ssActive ? ~(NumSlaves'(1) << selR) : '1;

    // Received word with this cycle's MISO sample merged in
    always_comb begin
        rxSampled = rxReg;
        if (sampleNow)
            rxSampled[bitPos(lsbR, lenR, bitCnt[LenW-1:0])] = MISO;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (hs) stateNext = StartSt;
            SETUP:   if (hpDone) stateNext = SHIFT;
            SHIFT:   if (lastEdge) stateNext = lastR ? EndSt : NEXT;
            NEXT:    if (hs) stateNext = SHIFT;
            HOLD:    if (hpDone) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register, configuration capture, SCLK/MOSI generation and Rx output
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cpolR   <= 1'b0;
            cphaR   <= 1'b0;
            lsbR    <= 1'b0;
            lastR   <= 1'b0;
            divR    <= '0;
            selR    <= '0;
            lenR    <= '0;
            divCnt  <= '0;
            phase   <= 1'b0;
            bitCnt  <= '0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            RxValid <= 1'b0;
            RxData  <= '0;
        end else begin
            state   <= stateNext;
            RxValid <= 1'b0;
            if (hs) begin
                lastR  <= TxLast;
                divCnt <= '0;
                phase  <= 1'b0;
                bitCnt <= '0;
                if (state == IDLE) begin
                    cpolR <= CPOL;
                    cphaR <= CPHA;
                    lsbR  <= Endianess;
                    divR  <= ClkDiv;
                    selR  <= SlaveSel;
                    lenR  <= WordLenM1;
                    SCLK  <= CPOL;
                    MOSI  <= TxData[bitPos(Endianess, WordLenM1, '0)];
                end else begin
                    MOSI  <= TxData[bitPos(lsbR, lenR, '0)];
                end
            end else if (state == SETUP || state == HOLD) begin
                divCnt <= tick ? '0 : divCnt + 1'b1;
            end else if (state == SHIFT) begin
                divCnt <= tick ? '0 : divCnt + 1'b1;
                if (tick) begin
                    SCLK  <= ~SCLK;
                    phase <= ~phase;
                    if (phase)
                        bitCnt <= bitCnt + 1'b1;
                    if (!cphaR && phase && !lastEdge)
                        MOSI <= txReg[bitPos(lsbR, lenR, bitNext)];
                    if (cphaR && !phase && bitCnt != '0)
                        MOSI <= txReg[bitPos(lsbR, lenR, bitCnt[LenW-1:0])];
                    if (lastEdge) begin
                        RxValid <= 1'b1;
                        RxData  <= rxSampled;
                    end
                end
            end
        end
    end

    // Half-period counter for the SS guard states
    always_ff @(posedge clk) begin
        if (reset)
            hpCnt <= '0;
        else if ((state == SETUP || state == HOLD) && tick)
            hpCnt <= hpDone ? '0 : hpCnt + 1'b1;
    end

    // Shift data registers (no reset; reloaded on every handshake)
    always_ff @(posedge clk) begin
        if (hs) begin
            txReg <= TxData;
            rxReg <= '0;
        end else begin
            rxReg <= rxSampled;
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed testbench for spi_master_multi: modes 0/3, bit order, bursts with
// gaps, reset abort, out-of-range slave select and the optional SS guard.
`timescale 1ns/1ps
module tb_spi_master_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CPOL = 1'b0, CPHA = 1'b0, Endianess = 1'b0;
    logic [7:0]  ClkDiv = '0;
    logic [1:0]  SlaveSel = '0;
    logic [4:0]  WordLenM1 = '0;
    logic        TxValid = 1'b0, TxLast = 1'b0;
    logic [31:0] TxData = '0;
    logic        TxReady, RxValid, Busy, SCLK, MOSI, MISO;
    logic [31:0] RxData;
    logic [3:0]  SS_n;
    logic        TxReady2, RxValid2, Busy2, SCLK2, MOSI2;
    logic [31:0] RxData2;
    logic [2:0]  SS_n2;

`ifdef SPI_SS_DELAY_EN
    localparam int ExpFirstEdge = 12, ExpRxAt = 16, ExpSsLow = 24;
`else
    localparam int ExpFirstEdge = 4, ExpRxAt = 8, ExpSsLow = 8;
`endif

    spi_master_multi #(.MaxWordLen(32), .NumSlaves(4), .DivWidth(8), .SSDelay(2)) dut (
        .clk(clk), .reset(reset), .CPOL(CPOL), .CPHA(CPHA), .Endianess(Endianess),
        .ClkDiv(ClkDiv), .SlaveSel(SlaveSel), .WordLenM1(WordLenM1),
        .TxValid(TxValid), .TxReady(TxReady), .TxData(TxData), .TxLast(TxLast),
        .RxValid(RxValid), .RxData(RxData), .Busy(Busy), .SCLK(SCLK),
        .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n));

    // Three-slave instance: SlaveSel=3 is out of range here
    spi_master_multi #(.MaxWordLen(32), .NumSlaves(3), .DivWidth(8), .SSDelay(2)) dut2 (
        .clk(clk), .reset(reset), .CPOL(CPOL), .CPHA(CPHA), .Endianess(Endianess),
        .ClkDiv(ClkDiv), .SlaveSel(SlaveSel), .WordLenM1(WordLenM1),
        .TxValid(TxValid), .TxReady(TxReady2), .TxData(TxData), .TxLast(TxLast),
        .RxValid(RxValid2), .RxData(RxData2), .Busy(Busy2), .SCLK(SCLK2),
        .MOSI(MOSI2), .MISO(MOSI2), .SS_n(SS_n2));

    always #5 clk = ~clk;

    // Slave model (CPHA=1 style: drive next bit on each falling SCLK, LSB first)
    logic        useSlave = 1'b0;
    logic [31:0] slvWord = '0;
    logic        slvBit = 1'b0;
    int          slvCnt = 0;
    always @(negedge SCLK or negedge Busy) begin
        if (!Busy) slvCnt <= 0;
        else if (useSlave) begin
            slvBit <= slvWord[slvCnt];
            slvCnt <= slvCnt + 1;
        end
    end
    assign MISO = useSlave ? slvBit : MOSI;

    // Pin monitor: SCLK edges while busy, MOSI at rising edges, pulses, SS-low cycles
    int          edges = 0, rises = 0, rxPulses = 0, ssLow = 0;
    logic [31:0] mosiCap = '0;
    logic        sclkPrev = 1'b0, busyPrev = 1'b0;
    always @(negedge clk) begin
        if (SCLK !== sclkPrev && busyPrev) begin
            edges = edges + 1;
            if (SCLK) begin
                rises = rises + 1;
                mosiCap = {mosiCap[30:0], MOSI};
            end
        end
        if (RxValid) rxPulses = rxPulses + 1;
        if (SS_n != 4'hF) ssLow = ssLow + 1;
        sclkPrev = SCLK;
        busyPrev = Busy;
    end

    int checks = 0, errors = 0;
    int e0 = 0, r0 = 0, p0 = 0, s0 = 0;
    int n, k;
    logic bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        e0 = edges; r0 = rises; p0 = rxPulses; s0 = ssLow;
    endtask

    task automatic cfg(input logic cpol, input logic cpha, input logic lsb,
                       input logic [7:0] div, input logic [1:0] sel, input logic [4:0] len);
        CPOL = cpol; CPHA = cpha; Endianess = lsb; ClkDiv = div; SlaveSel = sel; WordLenM1 = len;
    endtask

    // Present a word and hold it until the handshake edge
    task automatic send(input logic [31:0] d, input logic last);
        int w;
        @(negedge clk);
        TxValid = 1'b1; TxData = d; TxLast = last;
        w = 0;
        while (!TxReady && w < 200) begin @(negedge clk); w++; end
        check("send_ready", TxReady, 1'b1);
        @(posedge clk); #1;
        TxValid = 1'b0; TxLast = 1'b0;
    endtask

    // Called at a negedge; counts negedges until RxValid
    task automatic waitRx(output int cnt);
        cnt = 0;
        while (!RxValid && cnt < 2000) begin @(negedge clk); cnt++; end
        check("rx_valid_seen", RxValid, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txready", TxReady, 1'b0);
        check("rst_rxvalid", RxValid, 1'b0);
        check("rst_rxdata", RxData, 32'h0);
        check("rst_busy", Busy, 1'b0);
        check("rst_sclk", SCLK, 1'b0);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_ssn", SS_n, 4'hF);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_txready", TxReady, 1'b1);

        // Mode 0, MSB-first, 8 bits, ClkDiv=1, loopback
        cfg(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 5'd7);
        send(32'hA5, 1'b1);
        snap();
        @(negedge clk);
        check("m0_ssn", SS_n, 4'b1110);
        check("m0_txready_shift", TxReady, 1'b0);
        waitRx(n);
        check("m0_shift_cycles", n, 32);
        check("m0_rxdata", RxData, 32'h0000_00A5);
        check("m0_ssn_done", SS_n, 4'hF);
        check("m0_txready_done", TxReady, 1'b0);
        @(negedge clk);
        check("m0_rxvalid_pulse", RxValid, 1'b0);
        check("m0_txready_idle", TxReady, 1'b1);
        @(posedge clk); #1;
        check("m0_rises", rises - r0, 8);
        check("m0_edges", edges - e0, 16);
        check("m0_mosi_bits", mosiCap[7:0], 8'hA5);
        check("m0_sslow", ssLow - s0, 32);
        check("m0_pulses", rxPulses - p0, 1);

        // Mode 3, LSB-first, 12 bits, ClkDiv=0, slave returns 0x3C1
        cfg(1'b1, 1'b1, 1'b1, 8'd0, 2'd2, 5'd11);
        useSlave = 1'b1; slvWord = 32'h3C1;
        send(32'h5A3, 1'b1);
        snap();
        @(negedge clk);
        check("m3_ssn", SS_n, 4'b1011);
        check("m3_sclk_idle_high", SCLK, 1'b1);
        waitRx(n);
        check("m3_shift_cycles", n, 24);
        check("m3_rxdata", RxData, 32'h3C1);
        @(negedge clk);
        check("m3_sclk_after", SCLK, 1'b1);
        @(posedge clk); #1;
        check("m3_mosi_bits", mosiCap[11:0], 12'hC5A);
        check("m3_rises", rises - r0, 12);
        useSlave = 1'b0;

        // Burst of three words, gap before the last, config toggled mid-burst
        cfg(1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 5'd7);
        send(32'h11, 1'b0);
        snap();
        CPOL = 1'b1; SlaveSel = 2'd3; ClkDiv = 8'd0;
        @(negedge clk);
        waitRx(n);
        check("b1_rxdata", RxData, 32'h11);
        check("b1_cycles", n, 32);
        check("b1_ssn_next", SS_n, 4'b1101);
        check("b1_txready_next", TxReady, 1'b1);
        send(32'h22, 1'b0);
        @(negedge clk);
        waitRx(n);
        check("b2_rxdata", RxData, 32'h22);
        check("b2_cycles", n, 32);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (SS_n != 4'b1101 || SCLK != 1'b0 || RxValid) bad = 1'b1;
        end
        check("burst_gap_flat", bad, 1'b0);
        send(32'h33, 1'b1);
        @(negedge clk);
        check("b3_ssn", SS_n, 4'b1101);
        waitRx(n);
        check("b3_rxdata", RxData, 32'h33);
        check("b3_ssn_done", SS_n, 4'hF);
        @(posedge clk); #1;
        check("burst_pulses", rxPulses - p0, 3);
        check("burst_rises", rises - r0, 24);

        // Reset at bit 4 of a 16-bit mode-3 word
        cfg(1'b1, 1'b1, 1'b0, 8'd1, 2'd0, 5'd15);
        send(32'h1234, 1'b1);
        snap();
        @(negedge clk);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ssn", SS_n, 4'hF);
        check("abort_sclk", SCLK, 1'b0);
        check("abort_busy", Busy, 1'b0);
        check("abort_rxvalid", RxValid, 1'b0);
        check("abort_txready", TxReady, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_txready_after", TxReady, 1'b1);
        check("abort_no_pulse", rxPulses - p0, 0);
        cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 5'd15);
        send(32'hBEEF, 1'b1);
        @(negedge clk);
        waitRx(n);
        check("beef_cycles", n, 32);
        check("beef_rxdata", RxData, 32'hBEEF);

        // 1-bit word, SlaveSel=3: valid on the 4-slave unit, out of range on the 3-slave unit
        cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 5'd0);
        send(32'hFFFF_FFFF, 1'b1);
        snap();
        @(negedge clk);
        check("sel3_ssn4", SS_n, 4'b0111);
        check("sel3_ssn3_none", SS_n2, 3'b111);
        waitRx(n);
        check("len1_cycles", n, 2);
        check("len1_rxdata", RxData, 32'h1);
        check("oor_rxvalid", RxValid2, 1'b1);
        check("oor_rxdata", RxData2, 32'h1);
        @(posedge clk); #1;
        check("len1_edges", edges - e0, 2);

        // SS guard timing, ClkDiv=3, 1-bit word
        cfg(1'b0, 1'b0, 1'b0, 8'd3, 2'd1, 5'd0);
        send(32'h1, 1'b1);
        snap();
        @(negedge clk);
        check("guard_ssn", SS_n, 4'b1101);
        k = 0;
        while (SCLK == 1'b0 && k < 100) begin @(negedge clk); k++; end
        check("guard_first_edge", k, ExpFirstEdge);
        while (!RxValid && k < 200) begin @(negedge clk); k++; end
        check("guard_rx_at", k, ExpRxAt);
        check("guard_rxdata", RxData, 32'h1);
        k = 0;
        while (Busy && k < 100) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        check("guard_sslow", ssLow - s0, ExpSsLow);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
